// File: rtl/button_repeat_controller_pkg.sv
// Shared definitions for the button repeat controller slice.
// Holds the command and FSM state encodings, the button index map and the
// fixed-priority button decode so every file interprets buttons identically.
package button_ctrl_pkg;

  // Decoded command coming from the current button levels
  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_INC  = 2'd1,
    CMD_DEC  = 2'd2,
    CMD_CLR  = 2'd3
  } cmd_t;

  // Controller states; the encoding is what appears on state_dbg
  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_DELAY        = 2'd1,
    ST_REPEAT       = 2'd2,
    ST_WAIT_RELEASE = 2'd3
  } state_t;

  localparam int NUM_BUTTONS = 5;
  localparam int BTN_INC_A   = 0;
  localparam int BTN_DEC_A   = 1;
  localparam int BTN_DEC_B   = 2;
  localparam int BTN_INC_B   = 3;
  localparam int BTN_CLR     = 4;

  // Increment beats decrement beats clear when several buttons are down
  function automatic cmd_t decodeCmd(input logic [NUM_BUTTONS-1:0] btn);
    cmd_t result;
    result = CMD_NONE;
    if (btn[BTN_INC_A] || btn[BTN_INC_B]) begin
      result = CMD_INC;
    end else if (btn[BTN_DEC_A] || btn[BTN_DEC_B]) begin
      result = CMD_DEC;
    end else if (btn[BTN_CLR]) begin
      result = CMD_CLR;
    end
    return result;
  endfunction

endpackage

// File: rtl/button_repeat_controller_if.sv
// Bundle between the debouncer side and the display side of the controller.
//   buttons     : debounced button levels into the controller
//   count       : counter value for the display
//   step_pulse  : one-cycle pulse per increment/decrement step
//   step_dir    : 1 = up, 0 = down, meaningful while step_pulse is high
//   clr_pulse   : one-cycle pulse when a clear executes
//   limit_pulse : one-cycle pulse when a step wraps or is clamped
//   state_dbg   : current controller state encoding
// master = environment driving buttons, slave = the controller.
interface button_repeat_controller_if #(
  parameter int WIDTH = 8
);
  logic [4:0]       buttons;
  logic [WIDTH-1:0] count;
  logic             step_pulse;
  logic             step_dir;
  logic             clr_pulse;
  logic             limit_pulse;
  logic [1:0]       state_dbg;

  modport master (
    output buttons,
    input  count, step_pulse, step_dir, clr_pulse, limit_pulse, state_dbg
  );

  modport slave (
    input  buttons,
    output count, step_pulse, step_dir, clr_pulse, limit_pulse, state_dbg
  );
endinterface

// File: rtl/button_repeat_controller_timer.sv
// repeat_timer: loadable down-counter that paces hold delay and auto-repeat.
//   clk, reset : clock and asynchronous active-low reset
//   i_load     : load i_value this cycle (takes priority over counting)
//   i_value    : value to load
//   i_dec      : count down by one, stopping at zero
//   o_zero     : current value is zero
module repeat_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_value;

  // Load wins over counting; counting parks at zero so the expiry is held
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_value <= '0;
    end else if (i_load) begin
      r_value <= i_value;
    end else if (i_dec && (r_value != '0)) begin
      r_value <= r_value - 1'b1;
    end
  end

  assign o_zero = (r_value == '0);

endmodule

// File: rtl/button_repeat_controller.sv
// Turns debounced button levels into paced up/down/clear commands and owns
// the display counter. A press steps once immediately; a held inc/dec steps
// again after HOLD_CYCLES and then every REPEAT_CYCLES; clear fires once.
//   clk    : system clock
//   reset  : asynchronous active-low reset
//   io_bus : slave side of button_repeat_controller_if (buttons in, count,
//            step/clear/limit pulses and state_dbg out)
module button_repeat_controller
  import button_ctrl_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int SATURATE      = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  button_repeat_controller_if.slave    io_bus
);

  localparam int MAX_CYCLES = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TIMER_W    = $clog2(MAX_CYCLES);
  localparam logic [TIMER_W-1:0] HOLD_LOAD   = TIMER_W'(HOLD_CYCLES - 1);
  localparam logic [TIMER_W-1:0] REPEAT_LOAD = TIMER_W'(REPEAT_CYCLES - 1);
  localparam logic [WIDTH-1:0]   COUNT_MAX   = '1;

  state_t             r_state, w_nextState;
  cmd_t               r_latchCmd, w_nextLatch, w_cmd;
  logic               w_act, w_newPress;
  logic               w_timerLoad, w_timerDec, w_timerZero;
  logic [TIMER_W-1:0] w_timerValue;
  logic [WIDTH-1:0]   r_count;
  logic               r_stepPulse, r_stepDir, r_clrPulse, r_limitPulse;

  assign w_cmd = decodeCmd(io_bus.buttons);

  repeat_timer #(.WIDTH(TIMER_W)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_timerLoad),
    .i_value (w_timerValue),
    .i_dec   (w_timerDec),
    .o_zero  (w_timerZero)
  );

  // State and latched command register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_latchCmd <= CMD_NONE;
    end else begin
      r_state    <= w_nextState;
      r_latchCmd <= w_nextLatch;
    end
  end

  // Next-state logic. A changed command while counting down is handled as a
  // fresh press in the same cycle, so switching direction never loses a step.
  always_comb begin
    w_nextState  = r_state;
    w_nextLatch  = r_latchCmd;
    w_act        = 1'b0;
    w_newPress   = 1'b0;
    w_timerLoad  = 1'b0;
    w_timerDec   = 1'b0;
    w_timerValue = HOLD_LOAD;
    case (r_state)
      ST_IDLE: begin
        w_newPress = (w_cmd != CMD_NONE);
      end
      ST_DELAY, ST_REPEAT: begin
        if (w_cmd == CMD_NONE) begin
          w_nextState = ST_IDLE;
        end else if (w_cmd != r_latchCmd) begin
          w_newPress = 1'b1;
        end else if (w_timerZero) begin
          w_act        = 1'b1;
          w_timerLoad  = 1'b1;
          w_timerValue = REPEAT_LOAD;
          w_nextState  = ST_REPEAT;
        end else begin
          w_timerDec = 1'b1;
        end
      end
      ST_WAIT_RELEASE: begin
        if (w_cmd == CMD_NONE) begin
          w_nextState = ST_IDLE;
        end else if (w_cmd != CMD_CLR) begin
          w_newPress = 1'b1;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
    if (w_newPress) begin
      w_act = 1'b1;
      if (w_cmd == CMD_CLR) begin
        w_nextState = ST_WAIT_RELEASE;
      end else begin
        w_nextLatch  = w_cmd;
        w_timerLoad  = 1'b1;
        w_timerValue = HOLD_LOAD;
        w_nextState  = ST_DELAY;
      end
    end
  end

  // Counter and pulse registers; an action updates count and its pulse on
  // the same edge so the display sees the new value alongside the pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count      <= '0;
      r_stepPulse  <= 1'b0;
      r_stepDir    <= 1'b0;
      r_clrPulse   <= 1'b0;
      r_limitPulse <= 1'b0;
    end else begin
      r_stepPulse  <= 1'b0;
      r_stepDir    <= 1'b0;
      r_clrPulse   <= 1'b0;
      r_limitPulse <= 1'b0;
      if (w_act) begin
        case (w_cmd)
          CMD_INC: begin
            r_stepPulse <= 1'b1;
            r_stepDir   <= 1'b1;
            if (r_count == COUNT_MAX) begin
              r_limitPulse <= 1'b1;
              r_count      <= (SATURATE != 0) ? COUNT_MAX : '0;
            end else begin
              r_count <= r_count + 1'b1;
            end
          end
          CMD_DEC: begin
            r_stepPulse <= 1'b1;
            if (r_count == '0) begin
              r_limitPulse <= 1'b1;
              r_count      <= (SATURATE != 0) ? '0 : COUNT_MAX;
            end else begin
              r_count <= r_count - 1'b1;
            end
          end
          CMD_CLR: begin
            r_clrPulse <= 1'b1;
            r_count    <= '0;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign io_bus.count       = r_count;
  assign io_bus.step_pulse  = r_stepPulse;
  assign io_bus.step_dir    = r_stepDir;
  assign io_bus.clr_pulse   = r_clrPulse;
  assign io_bus.limit_pulse = r_limitPulse;
  assign io_bus.state_dbg   = r_state;

endmodule

// File: tb/tb_button_repeat_controller.sv
// Bench for button_repeat_controller: a wrapping and a saturating instance
// share clock, reset and buttons, and are compared every cycle against a
// press-timeline model (press start, hold age, step schedule e, e+H, e+H+kR).
module tb_button_repeat_controller;

  localparam int W    = 8;
  localparam int H    = 8;
  localparam int R    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] btn;
  int         testCount = 0;
  int         failCount = 0;

  // Reference model state
  int          pressCmd;
  int          age;
  int          cnt0;
  int          cnt1;
  logic [13:0] exp0;
  logic [13:0] exp1;
  logic [13:0] obs0;
  logic [13:0] obs1;

  always #5 clk = ~clk;

  button_repeat_controller_if #(.WIDTH(W)) bus0 ();
  button_repeat_controller_if #(.WIDTH(W)) bus1 ();

  assign bus0.buttons = btn;
  assign bus1.buttons = btn;

  button_repeat_controller #(
    .WIDTH(W), .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .SATURATE(0)
  ) dutWrap (
    .clk    (clk),
    .reset  (rst_n),
    .io_bus (bus0)
  );

  button_repeat_controller #(
    .WIDTH(W), .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .SATURATE(1)
  ) dutSat (
    .clk    (clk),
    .reset  (rst_n),
    .io_bus (bus1)
  );

  // Direction only matters while a step pulse is present
  assign obs0 = {bus0.count, bus0.step_pulse, bus0.step_pulse & bus0.step_dir,
                 bus0.clr_pulse, bus0.limit_pulse, bus0.state_dbg};
  assign obs1 = {bus1.count, bus1.step_pulse, bus1.step_pulse & bus1.step_dir,
                 bus1.clr_pulse, bus1.limit_pulse, bus1.state_dbg};

  task automatic modelReset();
    cnt0     = 0;
    cnt1     = 0;
    pressCmd = 0;
    age      = 0;
    exp0     = '0;
    exp1     = '0;
  endtask

  // One clock edge of the press timeline: cmd 0 none, 1 inc, 2 dec, 3 clr
  task automatic modelEdge(input logic [4:0] b);
    int cmd;
    int st;
    bit act = 0;
    bit s = 0;
    bit d = 0;
    bit c = 0;
    bit l0 = 0;
    bit l1 = 0;
    cmd = (b[0] | b[3]) ? 1 : (b[1] | b[2]) ? 2 : b[4] ? 3 : 0;
    if (cmd == 0) begin
      pressCmd = 0;
    end else if (cmd != pressCmd) begin
      pressCmd = cmd;
      age      = 0;
      act      = 1;
    end else if (cmd != 3) begin
      age++;
      if (age == H || (age > H && ((age - H) % R) == 0)) act = 1;
    end
    if (act && cmd == 1) begin
      s  = 1;
      d  = 1;
      l0 = (cnt0 == MAXV);
      cnt0 = (cnt0 + 1) % (MAXV + 1);
      l1 = (cnt1 == MAXV);
      if (cnt1 < MAXV) cnt1++;
    end else if (act && cmd == 2) begin
      s  = 1;
      l0 = (cnt0 == 0);
      cnt0 = (cnt0 + MAXV) % (MAXV + 1);
      l1 = (cnt1 == 0);
      if (cnt1 > 0) cnt1--;
    end else if (act && cmd == 3) begin
      c    = 1;
      cnt0 = 0;
      cnt1 = 0;
    end
    st   = (pressCmd == 0) ? 0 : (pressCmd == 3) ? 3 : (age < H) ? 1 : 2;
    exp0 = {W'(cnt0), s, d, c, l0, 2'(st)};
    exp1 = {W'(cnt1), s, d, c, l1, 2'(st)};
  endtask

  // Drive buttons, take one edge, advance the model, settle
  task automatic applyStimulus(input logic [4:0] b);
    btn = b;
    @(posedge clk);
    modelEdge(b);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    btn   = 5'b00001;
    modelReset();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      testCount++;
      if (obs0 !== 14'd0 || obs1 !== 14'd0) begin
        failCount++;
        $display("[TB] FAIL reset_hold cyc %0d: got %h/%h want 0", i, obs0, obs1);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(5'b00001);
    testCount++;
    if (obs0 !== exp0 || bus0.count !== 8'd1) begin
      failCount++;
      $display("[TB] FAIL reset_first_step: got %h want %h (count 1)", obs0, exp0);
    end
    applyStimulus(5'b00000);
    testCount++;
    if (obs0 !== exp0) begin
      failCount++;
      $display("[TB] FAIL reset_release: got %h want %h", obs0, exp0);
    end
  endtask

  task automatic test_single_press();
    int steps = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(i < 3 ? 5'b00001 : 5'b00000);
      steps += bus0.step_pulse;
      testCount++;
      if (obs0 !== exp0 || obs1 !== exp1) begin
        failCount++;
        $display("[TB] FAIL single_press cyc %0d: got %h/%h want %h/%h", i, obs0, obs1, exp0, exp1);
      end
    end
    testCount++;
    if (steps !== 1) begin
      failCount++;
      $display("[TB] FAIL single_press_count: got %0d steps want 1", steps);
    end
  endtask

  task automatic test_hold_repeat();
    int steps = 0;
    applyStimulus(5'b10000);
    applyStimulus(5'b00000);
    for (int i = 0; i < 22; i++) begin
      applyStimulus(i < 20 ? 5'b01000 : 5'b00000);
      steps += bus0.step_pulse;
      testCount++;
      if (obs0 !== exp0 || obs1 !== exp1) begin
        failCount++;
        $display("[TB] FAIL hold_repeat cyc %0d: got %h/%h want %h/%h", i, obs0, obs1, exp0, exp1);
      end
    end
    testCount++;
    if (steps !== 4 || bus0.count !== 8'd4 || bus0.state_dbg !== 2'd0) begin
      failCount++;
      $display("[TB] FAIL hold_repeat_total: got steps %0d count %0d state %0d want 4 4 0",
               steps, bus0.count, bus0.state_dbg);
    end
  endtask

  task automatic test_limits();
    logic [4:0] seq [6] = '{5'b10000, 5'b00000, 5'b00100, 5'b00000, 5'b00001, 5'b00000};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(seq[i]);
      testCount++;
      if (obs0 !== exp0 || obs1 !== exp1) begin
        failCount++;
        $display("[TB] FAIL limits_single cyc %0d: got %h/%h want %h/%h", i, obs0, obs1, exp0, exp1);
      end
    end
    for (int i = 0; i < 1100; i++) begin
      applyStimulus(5'b00001);
      testCount++;
      if (obs0 !== exp0 || obs1 !== exp1) begin
        failCount++;
        $display("[TB] FAIL limits_hold cyc %0d: got %h/%h want %h/%h", i, obs0, obs1, exp0, exp1);
      end
    end
    testCount++;
    if (bus1.count !== 8'd255) begin
      failCount++;
      $display("[TB] FAIL limits_saturated: got %0d want 255", bus1.count);
    end
    applyStimulus(5'b00000);
  endtask

  task automatic test_priority();
    for (int i = 0; i < 30; i++) begin
      applyStimulus(i < 14 ? 5'b00011 : (i < 28 ? 5'b00010 : 5'b00000));
      testCount++;
      if (obs0 !== exp0 || obs1 !== exp1) begin
        failCount++;
        $display("[TB] FAIL priority cyc %0d: got %h/%h want %h/%h", i, obs0, obs1, exp0, exp1);
      end
    end
  endtask

  task automatic test_clear();
    int clears = 0;
    applyStimulus(5'b10000);
    applyStimulus(5'b00000);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(5'b00001);
      applyStimulus(5'b00000);
    end
    testCount++;
    if (bus0.count !== 8'd7) begin
      failCount++;
      $display("[TB] FAIL clear_setup: got %0d want 7", bus0.count);
    end
    for (int i = 0; i < 13; i++) begin
      applyStimulus(i < 12 ? 5'b10000 : 5'b00000);
      clears += bus0.clr_pulse;
      testCount++;
      if (obs0 !== exp0 || obs1 !== exp1) begin
        failCount++;
        $display("[TB] FAIL clear cyc %0d: got %h/%h want %h/%h", i, obs0, obs1, exp0, exp1);
      end
    end
    testCount++;
    if (clears !== 1) begin
      failCount++;
      $display("[TB] FAIL clear_once: got %0d pulses want 1", clears);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 11; i++) applyStimulus(5'b00001);
    testCount++;
    if (bus0.state_dbg !== 2'd2) begin
      failCount++;
      $display("[TB] FAIL async_setup: got state %0d want 2", bus0.state_dbg);
    end
    #3;
    rst_n = 1'b0;
    #1;
    modelReset();
    testCount++;
    if (obs0 !== exp0 || obs1 !== exp1) begin
      failCount++;
      $display("[TB] FAIL async_reset_immediate: got %h/%h want 0", obs0, obs1);
    end
    @(posedge clk);
    #1;
    testCount++;
    if (obs0 !== exp0) begin
      failCount++;
      $display("[TB] FAIL async_reset_held: got %h want %h", obs0, exp0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(5'b00000);
    testCount++;
    if (obs0 !== exp0 || obs1 !== exp1) begin
      failCount++;
      $display("[TB] FAIL async_reset_release: got %h/%h want %h/%h", obs0, obs1, exp0, exp1);
    end
  endtask

  task automatic test_random();
    logic [4:0] pat;
    int len;
    for (int burst = 0; burst < 60; burst++) begin
      pat = ($urandom_range(0, 3) == 0) ? 5'b00000 : 5'($urandom_range(0, 31));
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) begin
        applyStimulus(pat);
        testCount++;
        if (obs0 !== exp0 || obs1 !== exp1) begin
          failCount++;
          $display("[TB] FAIL random b%0d c%0d pat %b: got %h/%h want %h/%h",
                   burst, i, pat, obs0, obs1, exp0, exp1);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    btn   = 5'b00000;
    modelReset();
    test_reset();
    test_single_press();
    test_hold_repeat();
    test_limits();
    test_priority();
    test_clear();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
